// File: rtl/serial_subtracter_ctrl_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package serial_subtracter_ctrl_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtracter_ctrl_cell.sv
// One-bit full subtracter: d = x - y - br, with the borrow-out on br_next.
module full_subtracter_cell (
    input  logic x,
    input  logic y,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtracter_ctrl.sv
// Bit-serial a - b - bin controller driving one full-subtracter cell LSB first.
// Optional signed-overflow flag is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtracter_ctrl
    import serial_subtracter_ctrl_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sb_reg;
    logic [WIDTH-2:0] sr_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    logic             cell_d, cell_br_next;
    logic [WIDTH-1:0] sr_cat;
    logic             last_bit;

    full_subtracter_cell u_cell (
        .x       (sa_reg[0]),
        .y       (sb_reg[0]),
        .br      (br_reg),
        .d       (cell_d),
        .br_next (cell_br_next)
    );

    // SR keeps only the WIDTH-1 bits already produced; the current bit is
    // appended on top so the final result can be latched on the last edge.
    assign sr_cat   = {cell_d, sr_reg};
    assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_reg   <= '0;
            sb_reg   <= '0;
            sr_reg   <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg  <= a;
                        sb_reg  <= b;
                        br_reg  <= bin;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    sa_reg <= sa_reg >> 1;
                    sb_reg <= sb_reg >> 1;
                    sr_reg <= sr_cat[WIDTH-1:1];
                    br_reg <= cell_br_next;
                    // Hold the counter on the last bit so it never wraps.
                    if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        diff_reg <= sr_cat;
                        bout_reg <= cell_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    // The last cell output is the result sign bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if ((state_reg == IDLE) && start) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (last_bit) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`else
    logic unused_last_bit;
    assign unused_last_bit = last_bit;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtracter_ctrl.sv
// Directed bench: WIDTH=8 vector table and corner sequences, WIDTH=3 exhaustive sweep.
module tb_serial_subtracter_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start3, bin3, busy3, done3, bout3, ovf3;
    logic [2:0] a3, b3, diff3;

    int n_checks = 0;
    int n_fail   = 0;
    int done3_cnt = 0;

    always #5 clk = ~clk;

    serial_subtracter_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtracter_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .bin(bin3),
        .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
    );

    always @(negedge clk) begin
        if (done3 === 1'b1) done3_cnt++;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;   // value with the overflow flag built
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ovf_expect(input logic v);
`ifdef SERIAL_SUB_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    task automatic run_op8(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                           input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        int cyc;
        int bcnt;
        @(negedge clk);
        a8 = va; b8 = vb; bin8 = vbin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~va; b8 = ~vb; bin8 = ~vbin;
        cyc = 0;
        bcnt = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, cyc, 8);
        check({tag, "/busy_cycles"}, bcnt, 8);
        check({tag, "/diff"}, diff8, ed);
        check({tag, "/bout"}, bout8, eb);
        check({tag, "/ovf"}, ovf8, ovf_expect(eo));
        $display("op8 %s a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d", tag, va, vb, vbin, diff8, bout8, ovf8);
        @(negedge clk);
        check({tag, "/done_one_cycle"}, done8, 1'b0);
    endtask

    initial begin
        int cyc;
        int dcnt;
        logic [7:0] seen_diff;
        logic [6:0] v;
        logic [2:0] ea, eb3, ed3;
        logic       ebin, ebout, eovf;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/busy", busy8, 1'b0);
        check("rst/done", done8, 1'b0);
        check("rst/diff", diff8, 8'h00);
        check("rst/bout", bout8, 1'b0);
        check("rst/ovf", ovf8, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle/busy", busy8, 1'b0);
        check("idle/diff", diff8, 8'h00);

        for (int i = 0; i < 7; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff,
                    vecs[i].exp_bout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Second start during RUN must be dropped, not queued.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dcnt = 0;
        seen_diff = 8'h00;
        for (int k = 0; k < 30; k++) begin
            if (done8 === 1'b1) begin
                dcnt++;
                if (dcnt == 1) seen_diff = diff8;
            end
            @(negedge clk);
        end
        check("ignore/done_count", dcnt, 1);
        check("ignore/diff", seen_diff, 8'h0F);
        $display("op8 ignore a=10 b=01 -> diff=%02h dones=%0d", seen_diff, dcnt);

        // Reset in the fourth RUN cycle wipes everything at once.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst/busy_before", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst/busy", busy8, 1'b0);
        check("midrst/done", done8, 1'b0);
        check("midrst/diff", diff8, 8'h00);
        check("midrst/bout", bout8, 1'b0);
        $display("op8 midrst -> busy=%0d done=%0d diff=%02h bout=%0d", busy8, done8, diff8, bout8);
        @(negedge clk);
        rst_n = 1'b1;
        run_op8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, "post_rst");

        // WIDTH=3 exhaustive sweep with start held high: each op launches as soon as possible.
        @(negedge clk);
        v = 7'd0;
        {a3, b3, bin3} = v;
        start3 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            cyc = 0;
            while (busy3 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 20) check($sformatf("w3_%0d/accept_timeout", i), cyc, 0);
            v = 7'(i);
            ea = v[6:4]; eb3 = v[3:1]; ebin = v[0];
            ed3 = 3'(ea - eb3 - 3'(ebin));
            ebout = ({1'b0, ea} < ({1'b0, eb3} + 4'(ebin)));
            eovf = ovf_expect((ea[2] != eb3[2]) && (ed3[2] != ea[2]));
            v = 7'(i + 1);
            {a3, b3, bin3} = v;
            cyc = 0;
            while (done3 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("w3_%0d/latency", i), cyc, 3);
            check($sformatf("w3_%0d/diff", i), diff3, ed3);
            check($sformatf("w3_%0d/bout", i), bout3, ebout);
            check($sformatf("w3_%0d/ovf", i), ovf3, eovf);
            $display("op3 a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d", ea, eb3, ebin, diff3, bout3, ovf3);
            @(negedge clk);
        end
        start3 = 1'b0;
        repeat (10) @(negedge clk);
        check("w3/done_total", done3_cnt, 128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
